// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for the jacaranda-8 core.
// Fetches an 8-bit instruction over a ready/valid memory port, decodes the
// opcode and issues one-cycle enable strobes to the datapath. Includes a
// bus-timeout watchdog and a retired-instruction counter.
//
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   mem_req/we/dsel       memory request, write flag, data (1) / fetch (0) select
//   mem_ready, mem_rdata  request accepted this cycle, read data
//   flag                  compare flag from the datapath (used by je)
//   ir                    instruction register
//   reg_w_en, reg_src     register-file write strobe and source select
//   flag_w_en, ih_il_sel  flag write strobe, ldih/ldil nibble select
//   pc_inc, pc_load       PC increment / PC load strobes
//   illegal               one-cycle pulse on opcode 4'b0010
//   bus_err               sticky watchdog fault, core halted while set
//   retired               count of completed instructions
module cpu_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_dsel,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  input  logic       flag,
  output logic [7:0] ir,
  output logic       reg_w_en,
  output logic [1:0] reg_src,
  output logic       flag_w_en,
  output logic       ih_il_sel,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       illegal,
  output logic       bus_err,
  output logic [15:0] retired
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned RET_W  = 16;

  // Last wait count at which a missing mem_ready still keeps the request alive.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ILL  = 4'h2;
  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_JE   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_LDIH = 4'hC;
  localparam logic [3:0] OP_LDIL = 4'hD;
  localparam logic [3:0] OP_LD   = 4'hE;
  localparam logic [3:0] OP_ST   = 4'hF;

  localparam logic [1:0] SRC_RS  = 2'd0;
  localparam logic [1:0] SRC_ALU = 2'd1;
  localparam logic [1:0] SRC_IMM = 2'd2;
  localparam logic [1:0] SRC_MEM = 2'd3;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e              state_q;
  logic [7:0]          ir_q;
  logic [RET_W-1:0]    retired_q;
  logic                bus_err_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                reset_q;

  logic [3:0]          op;
  logic                req_state;
  logic                req_live;

  assign op      = ir_q[7:4];
  assign ir      = ir_q;
  assign retired = retired_q;
  assign bus_err = bus_err_q;

  // A pending request stays visible in the first reset cycle and drops once
  // reset has been held for a second cycle; it returns as soon as reset lifts.
  assign req_state = (state_q == S_FETCH) || (state_q == S_MEM);
  assign req_live  = req_state && !(reset && reset_q);

  // Memory port: held steady for the whole FETCH or MEM state.
  always_comb begin
    mem_req  = req_live;
    mem_dsel = req_live && (state_q == S_MEM);
    mem_we   = req_live && (state_q == S_MEM) && (op == OP_ST);
  end

  // Datapath strobes; all suppressed in any cycle where reset is asserted.
  always_comb begin
    reg_w_en  = 1'b0;
    reg_src   = SRC_RS;
    flag_w_en = 1'b0;
    ih_il_sel = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    illegal   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: pc_inc = mem_ready;
        S_EXEC: begin
          unique case (op)
            OP_MOV: begin
              reg_w_en = 1'b1;
              reg_src  = SRC_RS;
            end
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
              reg_w_en = 1'b1;
              reg_src  = SRC_ALU;
            end
            OP_CMP:  flag_w_en = 1'b1;
            OP_JE:   pc_load   = flag;
            OP_JMP:  pc_load   = 1'b1;
            OP_LDIH: begin
              reg_w_en  = 1'b1;
              reg_src   = SRC_IMM;
              ih_il_sel = 1'b1;
            end
            OP_LDIL: begin
              reg_w_en  = 1'b1;
              reg_src   = SRC_IMM;
            end
            OP_ILL:  illegal = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem_ready && (op == OP_LD)) begin
            reg_w_en = 1'b1;
            reg_src  = SRC_MEM;
          end
        end
        S_HALT: ;
        default: ;
      endcase
    end
  end

  // Sequencer state, instruction register, watchdog and retirement counter.
  always_ff @(posedge clock) begin
    reset_q <= reset;
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= 8'h00;
      retired_q <= '0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            state_q <= S_EXEC;
          end else if (wait_q == WAIT_LAST) begin
            bus_err_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_EXEC: begin
          wait_q <= '0;
          if ((op == OP_LD) || (op == OP_ST)) begin
            state_q <= S_MEM;
          end else begin
            retired_q <= retired_q + RET_W'(1);
            state_q   <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            retired_q <= retired_q + RET_W'(1);
            wait_q    <= '0;
            state_q   <= S_FETCH;
          end else if (wait_q == WAIT_LAST) begin
            bus_err_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_HALT: ;
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with TIMEOUT=4: per-cycle expected
// strobe vectors are queued as stimulus is applied and checked when sampled.
module tb_cpu_sequencer;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic        mem_dsel;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic        flag;
  logic [7:0]  ir;
  logic        reg_w_en;
  logic [1:0]  reg_src;
  logic        flag_w_en;
  logic        ih_il_sel;
  logic        pc_inc;
  logic        pc_load;
  logic        illegal;
  logic        bus_err;
  logic [15:0] retired;

  cpu_sequencer #(.TIMEOUT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_dsel  (mem_dsel),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .flag      (flag),
    .ir        (ir),
    .reg_w_en  (reg_w_en),
    .reg_src   (reg_src),
    .flag_w_en (flag_w_en),
    .ih_il_sel (ih_il_sel),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .retired   (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected output vector: {req, we, dsel, wen, src[1:0], fwe, ih, pci, pcl, ill, berr}
  localparam logic [11:0] NONE = 12'h000;
  localparam logic [11:0] REQ  = 12'h800;
  localparam logic [11:0] WE   = 12'h400;
  localparam logic [11:0] DSEL = 12'h200;
  localparam logic [11:0] WEN  = 12'h100;
  localparam logic [11:0] SRC1 = 12'h040;
  localparam logic [11:0] SRC2 = 12'h080;
  localparam logic [11:0] SRC3 = 12'h0C0;
  localparam logic [11:0] FWE  = 12'h020;
  localparam logic [11:0] IH   = 12'h010;
  localparam logic [11:0] PCI  = 12'h008;
  localparam logic [11:0] PCL  = 12'h004;
  localparam logic [11:0] ILL  = 12'h002;
  localparam logic [11:0] BERR = 12'h001;

  typedef struct {
    string       tag;
    logic [11:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
    end
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, sample at negedge.
  task automatic step(input string tag, input logic rst, input logic rdy,
                      input logic [7:0] rd, input logic flg, input logic [11:0] ex);
    exp_t e;
    exp_t got;
    reset     = rst;
    mem_ready = rdy;
    mem_rdata = rd;
    flag      = flg;
    e.tag = tag;
    e.vec = ex;
    exp_q.push_back(e);
    @(negedge clock);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      got = exp_q.pop_front();
      chk(got.tag, 16'({mem_req, mem_we, mem_dsel, reg_w_en, reg_src, flag_w_en,
                        ih_il_sel, pc_inc, pc_load, illegal, bus_err}), 16'(got.vec));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    flag      = 1'b0;
    @(posedge clock);
    #1;
    // Second reset cycle: request dropped, everything cleared.
    step("reset_hold", 1'b1, 1'b0, 8'h00, 1'b0, NONE);
    chk("reset_ir", 16'(ir), 16'h0000);
    chk("reset_retired", retired, 16'd0);
    chk("reset_bus_err", 16'(bus_err), 16'h0000);

    // add r1,r0 with zero wait states.
    step("add_fetch", 1'b0, 1'b1, 8'h14, 1'b0, REQ | PCI);
    step("add_exec",  1'b0, 1'b0, 8'h00, 1'b0, WEN | SRC1);
    chk("add_ir", 16'(ir), 16'h0014);
    chk("add_retired", retired, 16'd1);

    // ld with 3 wait states; ready lands on the last cycle before timeout.
    step("ld_fetch", 1'b0, 1'b1, 8'hE6, 1'b0, REQ | PCI);
    step("ld_exec",  1'b0, 1'b0, 8'h00, 1'b0, NONE);
    for (int i = 0; i < 3; i++)
      step("ld_wait", 1'b0, 1'b0, 8'h00, 1'b0, REQ | DSEL);
    step("ld_accept", 1'b0, 1'b1, 8'h5A, 1'b0, REQ | DSEL | WEN | SRC3);
    chk("ld_retired", retired, 16'd2);
    chk("ld_ir", 16'(ir), 16'h00E6);
    chk("ld_bus_err", 16'(bus_err), 16'h0000);

    // je not taken, je taken, cmp.
    step("je0_fetch", 1'b0, 1'b1, 8'hA1, 1'b0, REQ | PCI);
    step("je0_exec",  1'b0, 1'b0, 8'h00, 1'b0, NONE);
    step("je1_fetch", 1'b0, 1'b1, 8'hA1, 1'b0, REQ | PCI);
    step("je1_exec",  1'b0, 1'b0, 8'h00, 1'b1, PCL);
    step("cmp_fetch", 1'b0, 1'b1, 8'h96, 1'b0, REQ | PCI);
    step("cmp_exec",  1'b0, 1'b0, 8'h00, 1'b1, FWE);
    chk("cmp_retired", retired, 16'd5);

    // Illegal opcode, followed directly by the next fetch.
    step("ill_fetch",  1'b0, 1'b1, 8'h20, 1'b0, REQ | PCI);
    step("ill_exec",   1'b0, 1'b0, 8'h00, 1'b0, ILL);
    chk("ill_retired", retired, 16'd6);
    step("ldih_fetch", 1'b0, 1'b1, 8'hC7, 1'b0, REQ | PCI);
    step("ldih_exec",  1'b0, 1'b0, 8'h00, 1'b0, WEN | SRC2 | IH);
    step("ldil_fetch", 1'b0, 1'b1, 8'hD3, 1'b0, REQ | PCI);
    step("ldil_exec",  1'b0, 1'b0, 8'h00, 1'b0, WEN | SRC2);
    step("mov_fetch",  1'b0, 1'b1, 8'h01, 1'b0, REQ | PCI);
    step("mov_exec",   1'b0, 1'b0, 8'h00, 1'b0, WEN);
    step("jmp_fetch",  1'b0, 1'b1, 8'hB2, 1'b0, REQ | PCI);
    step("jmp_exec",   1'b0, 1'b0, 8'h00, 1'b0, PCL);
    chk("mov_retired", retired, 16'd10);

    // st interrupted by reset while waiting in MEM.
    step("st_fetch",   1'b0, 1'b1, 8'hF2, 1'b0, REQ | PCI);
    step("st_exec",    1'b0, 1'b0, 8'h00, 1'b0, NONE);
    step("st_wait",    1'b0, 1'b0, 8'h00, 1'b0, REQ | WE | DSEL);
    step("st_rst1",    1'b1, 1'b1, 8'h00, 1'b0, REQ | WE | DSEL);
    step("st_rst2",    1'b1, 1'b0, 8'h00, 1'b0, NONE);
    chk("st_rst_ir", 16'(ir), 16'h0000);
    chk("st_rst_retired", retired, 16'd0);

    // Restart, retire one instruction, then let the fetch time out.
    step("re_fetch", 1'b0, 1'b1, 8'h14, 1'b0, REQ | PCI);
    step("re_exec",  1'b0, 1'b0, 8'h00, 1'b0, WEN | SRC1);
    chk("re_retired", retired, 16'd1);
    for (int i = 0; i < 4; i++)
      step("to_wait", 1'b0, 1'b0, 8'h00, 1'b0, REQ);
    step("to_halt1", 1'b0, 1'b1, 8'h14, 1'b0, BERR);
    step("to_halt2", 1'b0, 1'b1, 8'h14, 1'b1, BERR);
    chk("to_retired", retired, 16'd1);
    chk("to_ir", 16'(ir), 16'h0014);
    step("to_reset", 1'b1, 1'b1, 8'h14, 1'b0, BERR);
    chk("to_clear", 16'(bus_err), 16'h0000);
    step("post_fetch", 1'b0, 1'b1, 8'h96, 1'b0, REQ | PCI);
    step("post_exec",  1'b0, 1'b0, 8'h00, 1'b0, FWE);
    chk("post_retired", retired, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
